music_playback_ctrl: RTL and testbench

- Reader side of the recording memory. It selects one stored song, resets that song's read pointer, and fetches entries one at a time with read_en pulses.
- Each entry is split into a note code and a beat length. The note is held on note_out for the required number of clock cycles, followed by a short silent gap.
- Sits between the top-level FSM/UI and the buzzer/tone generator. Supports play, pause and stop.

---
 rtl/music_playback_ctrl.sv | 140 ++++++++++++++
 tb/tb_music_playback_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/music_playback_ctrl.sv
// Song playback sequencer: resets a memory unit's read pointer, fetches {note,len} entries
// one at a time, and times each note and its trailing silent gap. Supports play, pause and stop.
module music_playback_ctrl #(
  parameter int unsigned NOTE_W     = 5,
  parameter int unsigned LEN_W      = 3,
  parameter int unsigned DATA_WIDTH = NOTE_W + LEN_W,
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned IDX_W      = 10,
  parameter int unsigned BEAT_TICKS = 12500000,
  parameter int unsigned GAP_TICKS  = 1250000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  play,
  input  logic                  stop,
  input  logic                  pause,
  input  logic [SEL_W-1:0]      song_sel,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_valid,
  input  logic [IDX_W-1:0]      mem_duration,
  output logic [SEL_W-1:0]      mem_select,
  output logic                  mem_read_en,
  output logic                  mem_read_rst,
  output logic [NOTE_W-1:0]     note_out,
  output logic                  note_valid,
  output logic                  playing,
  output logic                  paused,
  output logic [IDX_W-1:0]      index,
  output logic                  done
);

  localparam int unsigned MAX_TICKS = ((2 ** LEN_W) - 1) * BEAT_TICKS;
  localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);
  localparam logic [CNT_W-1:0] GAP_CNT = CNT_W'(GAP_TICKS);

  typedef enum logic [2:0] {
    S_IDLE, S_RST_PTR, S_FETCH, S_WAIT, S_PLAY, S_GAP, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                paused_q, paused_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [LEN_W-1:0]    len_w;
  logic [NOTE_W-1:0]   note_w;

  assign len_w  = mem_data[LEN_W-1:0];
  assign note_w = mem_data[DATA_WIDTH-1:LEN_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      paused_q <= 1'b0;
      index_q  <= '0;
      cnt_q    <= '0;
      note_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      paused_q <= paused_d;
      index_q  <= index_d;
      cnt_q    <= cnt_d;
      note_q   <= note_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    paused_d = paused_q;
    index_d  = index_q;
    cnt_d    = cnt_q;
    note_d   = note_q;
    case (state_q)
      S_IDLE: if (play) begin
        sel_d   = song_sel;
        index_d = '0;
        state_d = S_RST_PTR;
      end
      S_RST_PTR: state_d = S_FETCH;
      S_FETCH:   state_d = (index_q == mem_duration) ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (!mem_valid) begin
          state_d = S_DONE;
        end else if (len_w == '0) begin
          index_d = index_q + IDX_W'(1);
          state_d = S_FETCH;
        end else begin
          note_d  = note_w;
          cnt_d   = CNT_W'((32'(len_w) * BEAT_TICKS) - 32'd1);
          state_d = S_PLAY;
        end
      end
      S_PLAY: if (!paused_q) begin
        // With no gap the note runs the counter to zero and goes straight to the next fetch.
        if (cnt_q == GAP_CNT && GAP_TICKS == 0) begin
          index_d = index_q + IDX_W'(1);
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == GAP_CNT) state_d = S_GAP;
        end
      end
      S_GAP: if (!paused_q) begin
        if (cnt_q == '0) begin
          index_d = index_q + IDX_W'(1);
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        paused_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (pause && (state_q == S_PLAY || state_q == S_GAP)) paused_d = ~paused_q;
    if (play && paused_q) paused_d = 1'b0;
    if (stop && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      paused_d = 1'b0;
      index_d  = index_q;
    end
  end

  assign mem_select   = sel_q;
  assign mem_read_rst = (state_q == S_RST_PTR);
  assign mem_read_en  = (state_q == S_FETCH) && (index_q != mem_duration);
  assign note_out     = (state_q == S_PLAY && !paused_q) ? note_q : '0;
  assign note_valid   = (state_q == S_PLAY) && !paused_q && (note_q != '0);
  assign playing      = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign paused       = paused_q;
  assign index        = index_q;

endmodule

// File: tb/tb_music_playback_ctrl.sv
// Bench for music_playback_ctrl: a per-cycle expected timeline is built from the song contents,
// then the DUT is driven through directed and randomized songs with pause/stop/reset events.
module tb_music_playback_ctrl;
  localparam int B = 4;
  localparam int G = 1;

  logic       clk = 1'b0;
  logic       rst, play, stop, pause;
  logic [2:0] song_sel;
  logic [7:0] mem_data = 8'h00;
  logic       mem_valid = 1'b0;
  logic [9:0] mem_duration;
  logic [2:0] mem_select;
  logic       mem_read_en, mem_read_rst, note_valid, playing, paused, done;
  logic [4:0] note_out;
  logic [9:0] index;

  music_playback_ctrl #(.NOTE_W(5), .LEN_W(3), .DATA_WIDTH(8), .SEL_W(3), .IDX_W(10),
                        .BEAT_TICKS(B), .GAP_TICKS(G)) dut (
    .clk(clk), .rst(rst), .play(play), .stop(stop), .pause(pause), .song_sel(song_sel),
    .mem_data(mem_data), .mem_valid(mem_valid), .mem_duration(mem_duration),
    .mem_select(mem_select), .mem_read_en(mem_read_en), .mem_read_rst(mem_read_rst),
    .note_out(note_out), .note_valid(note_valid), .playing(playing), .paused(paused),
    .index(index), .done(done));

  always #5 clk = ~clk;

  // Memory unit with one cycle of read latency; entries at or beyond nvalid come back invalid.
  logic [7:0] song_mem [0:15];
  int nvalid = 0;
  int ptr = 0;
  always @(posedge clk) begin
    if (mem_read_rst) ptr <= 0;
    else if (mem_read_en) begin
      mem_data  <= song_mem[ptr[3:0]];
      mem_valid <= (ptr < nvalid);
      ptr       <= ptr + 1;
    end
  end

  typedef struct {
    logic [4:0] note;
    logic nv, ren, rrst, dn, ply, psd, aud, lastc;
    logic [9:0] idx;
  } rec_t;
  rec_t tl[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cur_k   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cur_k, obs, exp);
    end
  endtask

  function automatic void push(input logic [4:0] n, input logic ren, input logic rrst,
                               input logic dn, input logic ply, input logic aud,
                               input logic lastc, input int idx);
    rec_t r;
    r.note = n; r.nv = (n != 0); r.ren = ren; r.rrst = rrst; r.dn = dn; r.ply = ply;
    r.psd = 1'b0; r.aud = aud; r.lastc = lastc; r.idx = 10'(idx);
    tl.push_back(r);
  endfunction

  // Expected cycle-by-cycle behaviour of one song, cycle k = k-th cycle after play is accepted.
  function automatic void build(input int dur);
    int i;
    int len;
    logic [4:0] nt;
    tl.delete();
    push(0, 0, 0, 0, 0, 0, 0, 0);
    push(0, 0, 1, 0, 1, 0, 0, 0);
    i = 0;
    forever begin
      if (i == dur) begin
        push(0, 0, 0, 0, 1, 0, 0, i);
        push(0, 0, 0, 1, 1, 0, 0, i);
        break;
      end
      push(0, 1, 0, 0, 1, 0, 0, i);
      push(0, 0, 0, 0, 1, 0, 0, i);
      if (i >= nvalid) begin
        push(0, 0, 0, 1, 1, 0, 0, i);
        break;
      end
      len = int'(song_mem[i][2:0]);
      nt  = song_mem[i][7:3];
      if (len != 0) begin
        for (int c = 0; c < len * B - G; c++) push(nt, 0, 0, 0, 1, 1, (G == 0 && c == len*B-1), i);
        for (int c = 0; c < G; c++) push(0, 0, 0, 0, 1, 1, (c == G - 1), i);
      end
      i++;
    end
    push(0, 0, 0, 0, 0, 0, 0, i);
  endfunction

  // Pause pulse in cycle p, resume play in cycle p+h: h frozen silent cycles follow cycle p.
  function automatic void add_pause(input int p, input int h);
    rec_t r;
    r = tl[p];
    r.note = 0; r.nv = 0; r.psd = 1; r.aud = 0; r.lastc = 0;
    for (int j = 0; j < h; j++) tl.insert(p + 1, r);
  endfunction

  task automatic chk_rec(input int k, input logic [2:0] sel);
    chk("note_out",   32'(note_out),     32'(tl[k].note));
    chk("note_valid", 32'(note_valid),   32'(tl[k].nv));
    chk("read_en",    32'(mem_read_en),  32'(tl[k].ren));
    chk("read_rst",   32'(mem_read_rst), 32'(tl[k].rrst));
    chk("done",       32'(done),         32'(tl[k].dn));
    chk("playing",    32'(playing),      32'(tl[k].ply));
    chk("paused",     32'(paused),       32'(tl[k].psd));
    chk("index",      32'(index),        32'(tl[k].idx));
    chk("mem_select", 32'(mem_select),   32'(sel));
  endtask

  task automatic run(input logic [2:0] sel, input int pp, input int ph,
                     input int ak, input int kind, output int dc);
    dc = 0;
    song_sel = sel;
    play = 1'b1;
    for (int k = 1; k < tl.size(); k++) begin
      @(posedge clk); @(negedge clk);
      play = 0; pause = 0; stop = 0;
      song_sel = 3'($urandom);
      cur_k = k;
      chk_rec(k, sel);
      if (done) dc = k;
      if (k == ak) begin
        if (kind == 1) begin stop = 1; play = 1; end
        else rst = 1;
        @(posedge clk); @(negedge clk);
        stop = 0; play = 0; rst = 0;
        cur_k = k + 1;
        chk("abort_playing", 32'(playing), 0);
        chk("abort_paused",  32'(paused), 0);
        chk("abort_done",    32'(done), 0);
        chk("abort_note",    32'(note_out), 0);
        chk("abort_index",   32'(index), (kind == 1) ? 32'(tl[k].idx) : 0);
        chk("abort_select",  32'(mem_select), (kind == 1) ? 32'(sel) : 0);
        for (int j = 0; j < 3; j++) begin
          @(posedge clk); @(negedge clk);
          chk("abort_idle_ren", 32'(mem_read_en | mem_read_rst | done), 0);
        end
        return;
      end
      if (pp > 0 && k == pp) pause = 1;
      if (pp > 0 && k == pp + ph) play = 1;
    end
  endtask

  task automatic load_song1();
    song_mem[0] = {5'd5, 3'd2};
    song_mem[1] = {5'd9, 3'd1};
    mem_duration = 10'd2;
    nvalid = 2;
  endtask

  initial begin
    int dc;
    int dur;
    int pp;
    int ph;
    int cands[$];
    logic [2:0] sel;
    rst = 1; play = 0; stop = 0; pause = 0; song_sel = 0; mem_duration = 0;
    for (int i = 0; i < 16; i++) song_mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst_playing", 32'(playing), 0);
    chk("rst_select",  32'(mem_select), 0);
    chk("rst_index",   32'(index), 0);
    chk("rst_outs",    32'({note_out, note_valid, paused, done, mem_read_en, mem_read_rst}), 0);

    load_song1();
    build(2);
    run(3'd1, 0, 0, 0, 0, dc);
    chk("song1_done_cycle", 32'(dc), 19);
    chk("song1_index", 32'(index), 2);

    song_mem[0] = {5'd0, 3'd1};
    song_mem[1] = {5'd7, 3'd0};
    song_mem[2] = {5'd3, 3'd1};
    mem_duration = 10'd3; nvalid = 3;
    build(3);
    run(3'd2, 0, 0, 0, 0, dc);
    chk("rest_skip_index", 32'(index), 3);

    load_song1();
    build(2);
    add_pause(6, 14);
    run(3'd4, 6, 14, 0, 0, dc);
    chk("pause_done_cycle", 32'(dc), 33);

    build(2);
    run(3'd5, 0, 0, 8, 1, dc);
    build(2);
    run(3'd6, 0, 0, 0, 0, dc);
    chk("restart_select", 32'(mem_select), 6);

    for (int i = 0; i < 3; i++) song_mem[i] = {5'(i + 2), 3'd1};
    mem_duration = 10'd3; nvalid = 1;
    build(3);
    run(3'd0, 0, 0, 0, 0, dc);
    chk("early_end_index", 32'(index), 1);

    mem_duration = 10'd0; nvalid = 0;
    build(0);
    run(3'd3, 0, 0, 0, 0, dc);
    chk("empty_done_cycle", 32'(dc), 3);

    load_song1();
    build(2);
    run(3'd7, 0, 0, 5, 2, dc);
    build(2);
    run(3'd2, 0, 0, 0, 0, dc);
    chk("after_rst_index", 32'(index), 2);

    for (int s = 0; s < 10; s++) begin
      dur = $urandom_range(0, 5);
      for (int i = 0; i < dur; i++) song_mem[i] = {5'($urandom), 3'($urandom_range(0, 3))};
      mem_duration = 10'(dur);
      nvalid = ($urandom_range(0, 3) == 0) ? $urandom_range(0, dur) : dur;
      build(dur);
      pp = 0; ph = 0;
      cands.delete();
      for (int k = 1; k < tl.size(); k++) if (tl[k].aud && !tl[k].lastc) cands.push_back(k);
      if (cands.size() > 0 && $urandom_range(0, 1) == 1) begin
        pp = cands[$urandom_range(0, cands.size() - 1)];
        ph = $urandom_range(1, 6);
        add_pause(pp, ph);
      end
      sel = 3'($urandom);
      run(sel, pp, ph, 0, 0, dc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
